// File: rtl/msdap_alu_sequencer.sv
// Per-channel MSDAP compute sequencer: walks rj/coeff memories, fetches delayed
// samples, accumulates each segment and applies the per-segment right shift.
module msdap_alu_sequencer #(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 40,
    parameter int NUM_SEG = 16,
    parameter int ADDR_W  = 8
) (
    input  logic                       Sclk,
    input  logic                       Reset_n,
    input  logic                       Clear,
    input  logic                       compute_enable,
    input  logic [ADDR_W-1:0]          data_wr_addr,
    output logic [$clog2(NUM_SEG)-1:0] rj_rd_addr,
    input  logic [ADDR_W-1:0]          rj_rd_data,
    output logic [ADDR_W-1:0]          coeff_rd_addr,
    input  logic [ADDR_W:0]            coeff_rd_data,
    output logic [ADDR_W-1:0]          data_rd_addr,
    input  logic [DATA_W-1:0]          data_rd_data,
    output logic [ACC_W-1:0]           y_out,
    output logic                       OutReady,
    output logic                       busy,
    output logic                       overrun
);

    localparam int SEG_W  = $clog2(NUM_SEG);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int EXT_W  = 8;
    localparam int LSB_W  = ACC_W - DATA_W - EXT_W;
    localparam int STAGES = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE, S_RJ_REQ, S_RJ_WAIT, S_MAC, S_DRAIN1, S_DRAIN2, S_SHIFT, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0]        base;
    logic [CNT_W-1:0]         samp_cnt;
    logic [SEG_W-1:0]         seg;
    logic [ADDR_W-1:0]        seg_left;
    logic [ADDR_W-1:0]        cptr;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  u;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  x_term;
    logic [STAGES:1]          vld_pipe;
    logic                     s2_use;
    logic                     s2_neg;
    logic [ADDR_W-1:0]        tap_k;
    logic                     tap_ok;
    logic                     last_seg;
    logic                     accept;
    logic                     issue;

    // vld_pipe[1]: coefficient word on coeff_rd_data; vld_pipe[2]: sample on data_rd_data
    assign tap_k         = coeff_rd_data[ADDR_W-1:0];
    assign tap_ok        = {1'b0, tap_k} < samp_cnt;
    assign rj_rd_addr    = seg;
    assign coeff_rd_addr = cptr;
    assign data_rd_addr  = vld_pipe[1] ? base - tap_k : '0;
    assign x_term        = {{EXT_W{data_rd_data[DATA_W-1]}}, data_rd_data, {LSB_W{1'b0}}};
    assign acc_sum       = acc + u;
    assign last_seg      = (seg == SEG_W'(NUM_SEG - 1));

    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n)
            state <= S_IDLE;
        else if (Clear)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (compute_enable) state_nxt = S_RJ_REQ;
            S_RJ_REQ:  state_nxt = S_RJ_WAIT;
            S_RJ_WAIT: state_nxt = (rj_rd_data == '0) ? S_SHIFT : S_MAC;
            S_MAC:     if (seg_left == ADDR_W'(1)) state_nxt = S_DRAIN1;
            S_DRAIN1:  state_nxt = S_DRAIN2;
            S_DRAIN2:  state_nxt = S_SHIFT;
            S_SHIFT:   state_nxt = last_seg ? S_DONE : S_RJ_REQ;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        accept = 1'b0;
        issue  = 1'b0;
        case (state)
            S_IDLE:  accept = compute_enable;
            S_MAC:   issue  = 1'b1;
            default: ;
        endcase
    end

    // Fetch pipeline: the sign and startup validity travel with each tap to the data stage
    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_pipe <= '0;
            s2_use   <= 1'b0;
            s2_neg   <= 1'b0;
        end else if (Clear) begin
            vld_pipe <= '0;
            s2_use   <= 1'b0;
            s2_neg   <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[1], issue};
            s2_use   <= vld_pipe[1] & tap_ok;
            s2_neg   <= coeff_rd_data[ADDR_W];
        end
    end

    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            base     <= '0;
            samp_cnt <= '0;
            seg      <= '0;
            seg_left <= '0;
            cptr     <= '0;
            acc      <= '0;
            u        <= '0;
            y_out    <= '0;
            OutReady <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else if (Clear) begin
            base     <= '0;
            samp_cnt <= '0;
            seg      <= '0;
            seg_left <= '0;
            cptr     <= '0;
            acc      <= '0;
            u        <= '0;
            y_out    <= '0;
            OutReady <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            OutReady <= 1'b0;
            // DONE still counts as busy, so a start request there is an overrun
            overrun  <= compute_enable && (state != S_IDLE);
            if (accept) begin
                base <= data_wr_addr;
                if (samp_cnt != CNT_MAX)
                    samp_cnt <= samp_cnt + 1'b1;
                acc  <= '0;
                seg  <= '0;
                busy <= 1'b1;
            end
            case (state)
                S_RJ_WAIT: seg_left <= rj_rd_data;
                S_MAC: begin
                    cptr     <= cptr + 1'b1;
                    seg_left <= seg_left - 1'b1;
                end
                S_SHIFT: begin
                    acc <= acc_sum >>> 1;
                    if (!last_seg)
                        seg <= seg + 1'b1;
                end
                S_DONE: begin
                    y_out    <= acc;
                    OutReady <= 1'b1;
                    busy     <= 1'b0;
                    cptr     <= '0;
                end
                default: ;
            endcase
            if (state == S_RJ_WAIT)
                u <= '0;
            else if (vld_pipe[2] && s2_use)
                u <= s2_neg ? u - x_term : u + x_term;
        end
    end

endmodule

// File: tb/tb_msdap_alu_sequencer.sv
// Bench for msdap_alu_sequencer: directed vector table, hand-written corner
// sequences and randomized runs against a plain-arithmetic reference model.
module tb_msdap_alu_sequencer;

    logic        Sclk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Clear = 1'b0;
    logic        compute_enable = 1'b0;
    logic [7:0]  data_wr_addr = 8'h00;
    logic [3:0]  rj_rd_addr;
    logic [7:0]  rj_rd_data;
    logic [7:0]  coeff_rd_addr;
    logic [8:0]  coeff_rd_data;
    logic [7:0]  data_rd_addr;
    logic [15:0] data_rd_data;
    logic [39:0] y_out;
    logic        OutReady;
    logic        busy;
    logic        overrun;

    msdap_alu_sequencer dut (
        .Sclk(Sclk), .Reset_n(Reset_n), .Clear(Clear), .compute_enable(compute_enable),
        .data_wr_addr(data_wr_addr), .rj_rd_addr(rj_rd_addr), .rj_rd_data(rj_rd_data),
        .coeff_rd_addr(coeff_rd_addr), .coeff_rd_data(coeff_rd_data),
        .data_rd_addr(data_rd_addr), .data_rd_data(data_rd_data), .y_out(y_out),
        .OutReady(OutReady), .busy(busy), .overrun(overrun)
    );

    always #5 Sclk = ~Sclk;

    logic [7:0]  rj_mem    [16];
    logic [8:0]  coeff_mem [256];
    logic [15:0] data_mem  [256];

    always @(posedge Sclk) begin
        rj_rd_data    <= rj_mem[rj_rd_addr];
        coeff_rd_data <= coeff_mem[coeff_rd_addr];
        data_rd_data  <= data_mem[data_rd_addr];
    end

    int ov_cnt = 0;
    int or_cnt = 0;
    int fd_hits = 0;
    always @(negedge Sclk) begin
        if (overrun) ov_cnt++;
        if (OutReady) or_cnt++;
        if (data_rd_addr == 8'hFD) fd_hits++;
    end

    int errors = 0;
    int checks = 0;
    int m_cnt = 0;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    function automatic longint sext40(input longint v);
        logic [39:0] t;
        t = v[39:0];
        return longint'($signed(t));
    endfunction

    // Reference: direct evaluation of the segment sums from the memory images
    function automatic logic [39:0] model_y(input logic [7:0] base);
        longint acc = 0;
        longint u;
        longint xv;
        logic [7:0] cp = 8'h00;
        logic [8:0] c;
        logic [7:0] k;
        for (int j = 0; j < 16; j++) begin
            u = 0;
            for (int i = 0; i < int'(rj_mem[j]); i++) begin
                c = coeff_mem[cp];
                cp = cp + 8'd1;
                k = c[7:0];
                if (int'(k) < m_cnt) begin
                    xv = longint'($signed(data_mem[base - k])) * 65536;
                    u = c[8] ? u - xv : u + xv;
                end
            end
            acc = sext40(acc + u) >>> 1;
        end
        return acc[39:0];
    endfunction

    function automatic int rj_sum();
        int s = 0;
        for (int i = 0; i < 16; i++) s += int'(rj_mem[i]);
        return s;
    endfunction

    task automatic start_ce(input logic [7:0] addr, input logic [15:0] x, output logic [39:0] exp);
        data_mem[addr] = x;
        if (m_cnt < 256) m_cnt++;
        exp = model_y(addr);
        @(negedge Sclk);
        compute_enable = 1'b1;
        data_wr_addr = addr;
        @(negedge Sclk);
        compute_enable = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [39:0] exp, input int bound, output int lat);
        lat = 0;
        while (OutReady !== 1'b1 && lat < 400) begin
            @(negedge Sclk);
            lat++;
        end
        checks++;
        if (OutReady !== 1'b1 || lat > bound) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, limit %0d", name, lat, bound);
        end
        check({name, " y_out"}, y_out, exp);
        @(negedge Sclk);
        check({name, " pulse"}, 40'(OutReady), 40'd0);
    endtask

    task automatic do_clear();
        @(negedge Sclk);
        Clear = 1'b1;
        @(negedge Sclk);
        Clear = 1'b0;
        m_cnt = 0;
        check("clear y_out", y_out, 40'd0);
        check("clear busy", 40'(busy), 40'd0);
    endtask

    task automatic set_uniform_rj(input logic [7:0] n);
        for (int i = 0; i < 16; i++) rj_mem[i] = n;
    endtask

    typedef struct {
        logic        clr;
        logic [8:0]  c0;
        logic [7:0]  addr;
        logic [15:0] x;
        logic [39:0] y;
        logic        fd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [39:0] e;
        logic [39:0] e2;
        int lat;
        int lref;
        int snap;
        int fd0;
        logic [7:0] kr;

        vecs[0] = '{1'b1, 9'h000, 8'h00, 16'h0001, 40'h0000000001, 1'b0};
        vecs[1] = '{1'b0, 9'h100, 8'h01, 16'h0002, 40'hFFFFFFFFFE, 1'b0};
        vecs[2] = '{1'b1, 9'h003, 8'h10, 16'h0005, 40'h0000000000, 1'b0};
        vecs[3] = '{1'b0, 9'h003, 8'h11, 16'h0006, 40'h0000000000, 1'b0};
        vecs[4] = '{1'b0, 9'h003, 8'h12, 16'h0007, 40'h0000000000, 1'b0};
        vecs[5] = '{1'b0, 9'h003, 8'h13, 16'h0008, 40'h0000000005, 1'b0};
        vecs[6] = '{1'b0, 9'h005, 8'h02, 16'h0009, 40'h0000000000, 1'b1};
        vecs[7] = '{1'b0, 9'h000, 8'h03, 16'h8000, 40'hFFFFFF8000, 1'b0};

        for (int i = 0; i < 16; i++) rj_mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            coeff_mem[i] = 9'h000;
            data_mem[i] = 16'h0000;
        end

        repeat (2) @(negedge Sclk);
        check("reset y_out", y_out, 40'd0);
        check("reset ctl", 40'({rj_rd_addr, coeff_rd_addr, data_rd_addr, OutReady, busy, overrun}), 40'd0);
        Reset_n = 1'b1;

        // Directed single-tap vectors: rj[0] = 1, all other segments empty
        set_uniform_rj(8'h00);
        rj_mem[0] = 8'h01;
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].clr) do_clear();
            coeff_mem[0] = vecs[v].c0;
            fd0 = fd_hits;
            start_ce(vecs[v].addr, vecs[v].x, e);
            wait_done($sformatf("vec%0d", v), vecs[v].y, 83, lat);
            check($sformatf("vec%0d wrap addr", v), 40'(fd_hits > fd0), 40'(vecs[v].fd));
        end

        // Full load: 256 taps, k = 0, x = 0x0100
        set_uniform_rj(8'd16);
        coeff_mem[0] = 9'h000;
        start_ce(8'h40, 16'h0100, e);
        wait_done("full", e, 338, lat);
        check("full const", y_out, 40'h000FFFF000);

        // Start request while busy: one overrun pulse, result unaffected
        snap = ov_cnt;
        start_ce(8'h41, 16'h0100, e);
        repeat (5) @(negedge Sclk);
        compute_enable = 1'b1;
        data_wr_addr = 8'h99;
        @(negedge Sclk);
        compute_enable = 1'b0;
        wait_done("overrun", e, 338, lat);
        repeat (3) @(negedge Sclk);
        check("overrun count", 40'(ov_cnt - snap), 40'd1);

        // Start request in the DONE cycle: measure latency, then hit that cycle
        set_uniform_rj(8'h00);
        rj_mem[15] = 8'h01;
        start_ce(8'h50, 16'h0004, e);
        wait_done("done ref", e, 83, lref);
        snap = or_cnt;
        start_ce(8'h51, 16'h0006, e2);
        repeat (lref - 1) @(negedge Sclk);
        compute_enable = 1'b1;
        data_wr_addr = 8'h52;
        @(negedge Sclk);
        compute_enable = 1'b0;
        check("done ovr ready", 40'({OutReady, overrun}), 40'b11);
        check("done ovr y_out", y_out, e2);
        @(negedge Sclk);
        check("done ovr busy", 40'(busy), 40'd0);
        repeat (150) @(negedge Sclk);
        check("done ovr no restart", 40'(or_cnt - snap), 40'd1);

        // Asynchronous reset in the middle of MAC
        set_uniform_rj(8'd16);
        start_ce(8'h60, 16'h0100, e);
        repeat (10) @(negedge Sclk);
        snap = or_cnt;
        #2 Reset_n = 1'b0;
        #1;
        check("async rst y_out", y_out, 40'd0);
        check("async rst ctl", 40'({rj_rd_addr, coeff_rd_addr, data_rd_addr, OutReady, busy, overrun}), 40'd0);
        @(negedge Sclk);
        Reset_n = 1'b1;
        m_cnt = 0;
        repeat (400) @(negedge Sclk);
        check("async rst no ready", 40'(or_cnt - snap), 40'd0);

        // Clear while busy aborts the computation
        start_ce(8'h70, 16'h0100, e);
        repeat (10) @(negedge Sclk);
        snap = or_cnt;
        do_clear();
        repeat (400) @(negedge Sclk);
        check("clear no ready", 40'(or_cnt - snap), 40'd0);

        // Randomized segment lengths (sums may exceed 256), signs, delays and samples
        for (int i = 0; i < 16; i++) rj_mem[i] = 8'($urandom_range(0, 24));
        for (int i = 0; i < 256; i++) begin
            kr = 8'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) kr = 8'($urandom);
            coeff_mem[i] = {1'($urandom_range(0, 1)), kr};
            data_mem[i] = 16'($urandom);
        end
        kr = 8'($urandom);
        for (int r = 0; r < 8; r++) begin
            start_ce(kr + 8'(r), 16'($urandom), e);
            wait_done($sformatf("rand%0d", r), e, 82 + rj_sum(), lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
